// File: rtl/audio_tone_pkg.sv
// Shared definitions for the tone sequencer: FSM encoding, default sample width
// and the saturating adder used by the output mixer.
`default_nettype none

package audio_tone_pkg;

  localparam int SAMPLE_W_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    LATCH = 3'd2,
    PLAY  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Adds two sign-extended operands and clamps the sum to a signed range of 'width' bits.
  function automatic longint sat_add(input longint a, input longint b, input int width);
    longint sum;
    longint hi;
    longint lo;
    sum = a + b;
    hi  = (longint'(1) <<< (width - 1)) - 1;
    lo  = -hi - 1;
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

`default_nettype wire

// File: rtl/square_wave_gen.sv
// Square-wave toggler: snd flips every half_period+1 enabled clocks; a zero
// half_period is a rest and keeps snd low.
`default_nettype none

module square_wave_gen #(
  parameter int DELAY_W = 19
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [DELAY_W-1:0] half_period,
  output logic               snd
);

  logic [DELAY_W-1:0] tone_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      tone_cnt <= '0;
      snd      <= 1'b0;
    end else if (en) begin
      if (tone_cnt == half_period) begin
        tone_cnt <= '0;
        snd      <= (half_period != '0) ? ~snd : 1'b0;
      end else begin
        tone_cnt <= tone_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tone_sequencer.sv
// ROM-driven square-wave melody player: one note per beat, optional looping,
// volume attenuation and a saturating mix onto the incoming audio sample.
`default_nettype none

module tone_sequencer
  import audio_tone_pkg::*;
#(
  parameter int NUM_TRACKS  = 4,
  parameter int NOTE_W      = 10,
  parameter int TRACK_LEN   = 1000,
  parameter int DELAY_W     = 19,
  parameter int BEAT_CYCLES = 2_500_000,
  parameter int AMPLITUDE   = 100_000_000,
  parameter int SAMPLE_W    = SAMPLE_W_DEFAULT,
  localparam int TRK_W      = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1,
  localparam int ADDR_W     = TRK_W + NOTE_W
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [TRK_W-1:0]    track_sel,
  input  logic                loop_en,
  input  logic [1:0]          volume,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [DELAY_W-1:0]  rom_q,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                busy,
  output logic                done
);

  localparam int BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [TRK_W:0]        TRK_LIM  = (TRK_W + 1)'(NUM_TRACKS);
  localparam logic [BEAT_W-1:0]     BEAT_TC  = BEAT_W'(BEAT_CYCLES - 1);
  localparam logic [NOTE_W-1:0]     NOTE_TC  = NOTE_W'(TRACK_LEN - 1);
  localparam logic [SAMPLE_W-1:0]   AMP      = SAMPLE_W'(AMPLITUDE);

  state_t state, state_n;

  logic [BEAT_W-1:0]          beat_cnt;
  logic [DELAY_W-1:0]         note_delay;
  logic [NOTE_W-1:0]          note_idx;
  logic [TRK_W-1:0]           track_q;
  logic                       start_ok;
  logic                       beat_last;
  logic                       last_note;
  logic                       snd;
  logic                       wave_rst;
  logic signed [SAMPLE_W-1:0] mag;
  logic signed [SAMPLE_W-1:0] tone;
  logic [SAMPLE_W-1:0]        mixed;

  // The address register doubles as the track and note-index store.
  assign note_idx  = rom_addr[NOTE_W-1:0];
  assign track_q   = rom_addr[ADDR_W-1:NOTE_W];
  assign start_ok  = start && !stop && ({1'b0, track_sel} < TRK_LIM);
  assign beat_last = (beat_cnt == BEAT_TC);
  assign last_note = (note_idx == NOTE_TC);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = IDLE;
      LOAD:    state_n = LATCH;
      LATCH:   state_n = PLAY;
      PLAY:    if (beat_last) state_n = (!last_note || loop_en) ? LOAD : DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (start_ok) state_n = LOAD;
    if (stop)     state_n = IDLE;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rom_addr   <= '0;
      beat_cnt   <= '0;
      note_delay <= '0;
      sample_out <= '0;
    end else begin
      sample_out <= mixed;
      if (start_ok) begin
        rom_addr <= {track_sel, {NOTE_W{1'b0}}};
        beat_cnt <= '0;
      end else if (!stop) begin
        case (state)
          LATCH: begin
            note_delay <= rom_q;
            beat_cnt   <= '0;
          end
          PLAY: begin
            if (beat_last) begin
              beat_cnt <= '0;
              if (!last_note)   rom_addr <= {track_q, note_idx + 1'b1};
              else if (loop_en) rom_addr <= {track_q, {NOTE_W{1'b0}}};
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Tone phase restarts at every note and is held cleared whenever not playing.
  assign wave_rst = reset || stop || (state != PLAY);

  square_wave_gen #(
    .DELAY_W (DELAY_W)
  ) u_wave (
    .clk         (CLOCK_50),
    .reset       (wave_rst),
    .en          (state == PLAY),
    .half_period (note_delay),
    .snd         (snd)
  );

  assign mag = $signed(AMP >> volume);

  always_comb begin
    tone = '0;
    if (state == PLAY && note_delay != '0) tone = snd ? mag : -mag;
  end

  assign mixed = SAMPLE_W'(sat_add(longint'($signed(sample_in)), longint'(tone), SAMPLE_W));

endmodule

`default_nettype wire

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer using a timeline model of note playback.
`default_nettype none

module tb_tone_sequencer;

  localparam int NT   = 3;
  localparam int NW   = 2;
  localparam int LEN  = 4;
  localparam int DW   = 8;
  localparam int BEAT = 8;
  localparam int AMP  = 1000;
  localparam int SW   = 32;
  localparam int NP   = BEAT + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic [1:0]    track_sel = '0;
  logic [1:0]    volume = '0;
  logic [3:0]    rom_addr;
  logic [DW-1:0] rom_q;
  logic [SW-1:0] sample_in = '0;
  logic [SW-1:0] sample_out;
  logic          busy;
  logic          done;
  logic [DW-1:0] rom [16];

  int checks = 0;
  int errors = 0;

  tone_sequencer #(
    .NUM_TRACKS (NT), .NOTE_W (NW), .TRACK_LEN (LEN), .DELAY_W (DW),
    .BEAT_CYCLES (BEAT), .AMPLITUDE (AMP), .SAMPLE_W (SW)
  ) dut (
    .CLOCK_50 (clk), .reset (reset), .start (start), .stop (stop),
    .track_sel (track_sel), .loop_en (loop_en), .volume (volume),
    .rom_addr (rom_addr), .rom_q (rom_q), .sample_in (sample_in),
    .sample_out (sample_out), .busy (busy), .done (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_q <= rom[rom_addr];

  // Tone during the cycle m clocks after the start edge: each note spends two
  // clocks fetching, then BEAT clocks playing; the wave starts low and flips
  // every d+1 playing clocks.
  function automatic longint tone_at(int trk, int m, int vol, int passes, int stop_at);
    int n;
    int p;
    int d;
    if (m < 0) return 0;
    if (stop_at >= 0 && m > stop_at) return 0;
    n = m / NP;
    p = m % NP;
    if (n >= passes * LEN || p < 2) return 0;
    d = int'(rom[trk * LEN + n % LEN]);
    if (d == 0) return 0;
    return ((((p - 2) / (d + 1)) % 2) == 1) ? longint'(AMP >> vol) : -longint'(AMP >> vol);
  endfunction

  function automatic longint sat(longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_track(int trk, int passes, int vol, longint sin, int stop_at,
                           int total, longint first_tone);
    int     end_m;
    bit     stopped;
    longint t;
    end_m     = passes * LEN * NP;
    sample_in = SW'(sin);
    volume    = 2'(vol);
    track_sel = 2'(trk);
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int m = 0; m < total; m++) begin
      stopped = (stop_at >= 0 && m > stop_at);
      t = (m == 0) ? first_tone : tone_at(trk, m - 1, vol, passes, stop_at);
      chk("sample_out", $signed(sample_out), sat(sin + t));
      chk("busy", 64'(busy), 64'(!stopped && m <= end_m));
      chk("done", 64'(done), 64'(!stopped && m == end_m));
      if (!stopped && m < end_m)
        chk("rom_addr", 64'(rom_addr), 64'(trk * LEN + (m / NP) % LEN));
      loop_en = (((m + 1) / (LEN * NP)) < passes);
      stop    = (m == stop_at);
      step();
    end
    stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int     trk;
    int     vol;
    int     passes;
    longint sin;

    for (int i = 0; i < 16; i++) rom[i] = DW'($urandom_range(0, 4));
    rom[0] = 8'd1;
    rom[4] = 8'd2; rom[5] = 8'd0; rom[6] = 8'd3; rom[7] = 8'd1;

    // reset state, with a nonzero input sample present
    reset = 1'b1;
    sample_in = 32'h0000_1234;
    repeat (3) step();
    chk("reset_rom_addr", 64'(rom_addr), 0);
    chk("reset_busy", 64'(busy), 0);
    chk("reset_done", 64'(done), 0);
    chk("reset_sample_out", 64'(sample_out), 0);
    reset = 1'b0;
    sample_in = '0;
    step();

    // single non-looped pass of track 1, then a two-pass loop of the same track
    run_track(1, 1, 0, 0, -1, LEN * NP + 3, 0);
    run_track(1, 2, 0, 0, -1, 2 * LEN * NP + 3, 0);

    // randomized tracks, volumes, input samples and loop counts
    repeat (4) begin
      trk    = int'($urandom_range(0, NT - 1));
      vol    = int'($urandom_range(0, 3));
      passes = int'($urandom_range(1, 2));
      sin    = longint'($urandom_range(0, 20000)) - 10000;
      run_track(trk, passes, vol, sin, -1, passes * LEN * NP + 3, 0);
    end

    // stop in the middle of note 2
    run_track(2, 1, 1, 500, 2 * NP + 4, 2 * NP + 8, 0);

    // start and stop together: remains idle
    track_sel = 2'd1;
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    repeat (3) begin
      chk("start_stop_busy", 64'(busy), 0);
      step();
    end

    // positive and negative saturation at volume 2
    run_track(0, 1, 2, 64'sh7FFF_FF80, -1, LEN * NP + 2, 0);
    run_track(0, 1, 2, -64'sh7FFF_FF80, -1, LEN * NP + 2, 0);

    // restart onto track 2 while track 1 is playing note 1
    run_track(1, 1, 0, 0, -1, 16, 0);
    run_track(2, 1, 0, 0, -1, LEN * NP + 3, tone_at(1, 16, 0, 1, -1));

    // reset while playing, then a start with an out-of-range track
    run_track(1, 1, 0, 0, -1, 2 * NP + 5, 0);
    sample_in = 32'h0000_0055;
    reset = 1'b1;
    step();
    chk("midreset_rom_addr", 64'(rom_addr), 0);
    chk("midreset_busy", 64'(busy), 0);
    chk("midreset_done", 64'(done), 0);
    chk("midreset_sample_out", 64'(sample_out), 0);
    reset = 1'b0;
    track_sel = 2'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) begin
      chk("bad_track_busy", 64'(busy), 0);
      chk("bad_track_rom_addr", 64'(rom_addr), 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
